// File: rtl/arb_mux_pkg.sv
// Shared types for the arbitrating output mux: the channel-selection mode.
package arb_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Wrap-around priority search: first set request at start, start+1, ... mod N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int SELW = $clog2(N);

    int pos;

    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = int'(start) + i;
            if (pos >= N) pos = pos - N;
            for (int k = 0; k < N; k++) begin
                if (k == pos && req[k]) begin
                    found = 1'b1;
                    idx   = SELW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// Fixed-select or round-robin channel mux feeding a single registered output stage.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [$clog2(CHANNELS)-1:0] sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(CHANNELS)-1:0] out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int SELW = $clog2(CHANNELS);

    logic [CHANNELS-1:0][WIDTH-1:0] lane_data;
    mode_e                          mode_q;
    logic [SELW-1:0]                ptr;
    logic [SELW-1:0]                ptr_next;
    logic                           load;
    logic                           fix_found;
    logic                           rr_found;
    logic [SELW-1:0]                rr_idx;
    logic                           cand_found;
    logic [SELW-1:0]                cand_idx;
    logic [WIDTH-1:0]               cand_data;
    logic                           grant;

    assign lane_data = in_data;
    assign mode_q    = mode_e'(mode);
    assign load      = !out_valid || out_ready;

    // Compare against each real channel so an out-of-range sel simply matches nothing.
    always_comb begin
        fix_found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SELW'(k)) fix_found = in_valid[k];
        end
    end

    rr_pick #(
        .N(CHANNELS)
    ) u_rr_pick (
        .req  (in_valid),
        .start(ptr),
        .found(rr_found),
        .idx  (rr_idx)
    );

    assign cand_found = (mode_q == MODE_RR) ? rr_found : fix_found;
    assign cand_idx   = (mode_q == MODE_RR) ? rr_idx   : sel;
    assign grant      = load && cand_found && !rst;

    always_comb begin
        cand_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cand_idx == SELW'(k)) cand_data = lane_data[k];
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ready
        assign in_ready[k] = grant && (cand_idx == SELW'(k));
    end

    assign ptr_next = (cand_idx == SELW'(CHANNELS - 1)) ? '0 : cand_idx + SELW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (grant) begin
            out_data  <= cand_data;
            out_sel   <= cand_idx;
            out_valid <= 1'b1;
            if (mode_q == MODE_RR) ptr <= ptr_next;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: 4-channel main instance plus a 3-channel instance for sel range.
module tb_arb_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [11:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [2:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [8:0]  in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [2:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_valid3;
    logic        out_ready3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(3), .CHANNELS(4)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(3), .CHANNELS(3)) u_dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 3'b000) begin errors++; $display("FAIL reset_data got %b exp 000", out_data); end
        checks++; if (out_sel !== 2'b00) begin errors++; $display("FAIL reset_sel got %b exp 00", out_sel); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", in_ready); end
    endtask

    task automatic test_fixed();
        rst = 1'b0; #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready1 got %b exp 0010", in_ready); end
        @(negedge clk);
        checks++; if (out_data !== 3'b100 || out_sel !== 2'd1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL fixed_out1 got d=%b s=%0d v=%b exp d=100 s=1 v=1", out_data, out_sel, out_valid); end
        sel = 2'd3; #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL fixed_ready3 got %b exp 1000", in_ready); end
        @(negedge clk);
        checks++; if (out_data !== 3'b001 || out_sel !== 2'd3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL fixed_out3 got d=%b s=%0d v=%b exp d=001 s=3 v=1", out_data, out_sel, out_valid); end
        sel = 2'd2; in_valid = 4'b1011; #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_nocand_ready got %b exp 0000", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== 3'b001 || out_sel !== 2'd3) begin
            errors++; $display("FAIL fixed_nocand_out got d=%b s=%0d v=%b exp d=001 s=3 v=0", out_data, out_sel, out_valid); end
    endtask

    task automatic test_rr_all();
        logic [2:0] exp_d [5];
        logic [3:0] exp_r [5];
        exp_d = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b000};
        exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== exp_r[i]) begin errors++; $display("FAIL rr_all_ready[%0d] got %b exp %b", i, in_ready, exp_r[i]); end
            @(negedge clk);
            checks++; if (out_data !== exp_d[i] || out_valid !== 1'b1) begin
                errors++; $display("FAIL rr_all_data[%0d] got d=%b v=%b exp d=%b v=1", i, out_data, out_valid, exp_d[i]); end
        end
    endtask

    task automatic test_rr_sparse();
        logic [1:0] exp_s [4];
        exp_s = '{2'd1, 2'd3, 2'd1, 2'd3};
        rst = 1'b1; mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_sel !== exp_s[i] || out_valid !== 1'b1) begin
                errors++; $display("FAIL rr_sparse_sel[%0d] got s=%0d v=%b exp s=%0d v=1", i, out_sel, out_valid, exp_s[i]); end
        end
    endtask

    task automatic test_backpressure();
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0000", i, in_ready); end
            @(negedge clk);
            checks++; if (out_data !== 3'b001 || out_sel !== 2'd3 || out_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d] got d=%b s=%0d v=%b exp d=001 s=3 v=1", i, out_data, out_sel, out_valid); end
        end
        out_ready = 1'b1; #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL stall_release_ready got %b exp 0001", in_ready); end
        @(negedge clk);
        checks++; if (out_data !== 3'b000 || out_sel !== 2'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_release_out got d=%b s=%0d v=%b exp d=000 s=0 v=1", out_data, out_sel, out_valid); end
    endtask

    task automatic test_drain();
        @(negedge clk);
        checks++; if (out_data !== 3'b100 || out_sel !== 2'd1) begin
            errors++; $display("FAIL drain_pre got d=%b s=%0d exp d=100 s=1", out_data, out_sel); end
        in_valid = 4'b0000; #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL drain_ready got %b exp 0000", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== 3'b100 || out_sel !== 2'd1) begin
            errors++; $display("FAIL drain_out got d=%b s=%0d v=%b exp d=100 s=1 v=0", out_data, out_sel, out_valid); end
    endtask

    task automatic test_mode_switch();
        // ptr is 2 here; a fixed-mode grant must leave it alone.
        mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mode_fixed_ready got %b exp 0001", in_ready); end
        @(negedge clk);
        mode = 1'b1; #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL mode_rr_ready got %b exp 0100", in_ready); end
        @(negedge clk);
        checks++; if (out_sel !== 2'd2 || out_data !== 3'b010) begin
            errors++; $display("FAIL mode_rr_out got d=%b s=%0d exp d=010 s=2", out_data, out_sel); end
    endtask

    task automatic test_midreset();
        in_valid = 4'b0010; #1;
        @(negedge clk);
        checks++; if (out_sel !== 2'd1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_pre got s=%0d v=%b exp s=1 v=1", out_sel, out_valid); end
        in_valid = 4'b1111; out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 3'b000 || out_sel !== 2'd0) begin
            errors++; $display("FAIL midrst_async got d=%b s=%0d v=%b exp d=000 s=0 v=0", out_data, out_sel, out_valid); end
        out_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ready got %b exp 0001", in_ready); end
        @(negedge clk);
        checks++; if (out_sel !== 2'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_first got s=%0d v=%b exp s=0 v=1", out_sel, out_valid); end
    endtask

    task automatic test_non_pow2();
        logic [1:0] exp_s [4];
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd0};
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1; #1;
        checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL np2_oor_ready got %b exp 000", in_ready3); end
        @(negedge clk);
        checks++; if (out_valid3 !== 1'b0 || out_data3 !== 3'b000 || out_sel3 !== 2'd0) begin
            errors++; $display("FAIL np2_oor_out got d=%b s=%0d v=%b exp d=000 s=0 v=0", out_data3, out_sel3, out_valid3); end
        sel3 = 2'd2; #1;
        checks++; if (in_ready3 !== 3'b100) begin errors++; $display("FAIL np2_sel2_ready got %b exp 100", in_ready3); end
        @(negedge clk);
        checks++; if (out_data3 !== 3'b110 || out_sel3 !== 2'd2 || out_valid3 !== 1'b1) begin
            errors++; $display("FAIL np2_sel2_out got d=%b s=%0d v=%b exp d=110 s=2 v=1", out_data3, out_sel3, out_valid3); end
        mode3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_sel3 !== exp_s[i]) begin
                errors++; $display("FAIL np2_rr_wrap[%0d] got s=%0d exp s=%0d", i, out_sel3, exp_s[i]); end
        end
    endtask

    initial begin
        in_data   = {3'b001, 3'b010, 3'b100, 3'b000};
        in_data3  = {3'b110, 3'b011, 3'b101};
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1;
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_drain();
        test_mode_switch();
        test_midreset();
        test_non_pow2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
